zebra_stop_filter: RTL
======================

// Module: zebra_stop_filter
// PURPOSE
//  Temporal hysteresis filter downstream of pattern_recognition. Consumes the
//  per-frame zebra verdict (crossing_detected, qualified by detection_valid) and
//  drives a debounced, fail-safe stop request in place of the raw AND.
//  Needs ON_FRAMES consecutive positive verdicts to assert stop. Holds stop for
//  at least HOLD_FRAMES verdicts, then needs OFF_FRAMES consecutive negatives to release it.
// PARAMETERS
//  ON_FRAMES      3         consecutive positive verdicts to assert stop (>=1)
//  OFF_FRAMES     5         consecutive negative verdicts to release stop (>=1)
//  HOLD_FRAMES    10        min verdicts counted in STOP before release may begin (>=0)
//  TIMEOUT_CYC    2000000   clk cycles without a verdict before stale fail-safe (>=1)
// PORTS
//  clk              in   1   video clock (clk_video domain)
//  rst_n            in   1   asynchronous active-low reset
//  detection_valid  in   1   verdict-ready level from pattern_recognition
//  crossing_detected in  1   verdict value, sampled with detection_valid edge
//  flush            in   1   sync clear to CLEAR state, counters zeroed
//  stop             out  1   debounced stop request (registered)
//  stop_pulse       out  1   one-cycle pulse on stop 0->1
//  stale            out  1   no verdict for TIMEOUT_CYC cycles
//  state            out  2   FSM state: 0 CLEAR, 1 CONFIRM, 2 STOP, 3 RELEASE
//  verdict_count    out  16  verdicts consumed since reset/flush, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, rst_n=0): state=CLEAR, stop=0, stop_pulse=0, stale=0,
//   verdict_count=0, all internal counters 0, dv_q=0.
//  Verdict event: ev = detection_valid & ~dv_q (rising edge). dv_q is registered each cycle.
//   pos = ev & crossing_detected; neg = ev & ~crossing_detected.
//  Latency: the event occurs in cycle t. state and stop update at the clock edge ending cycle t.
//   Both are visible in cycle t+1. stop_pulse is high in cycle t+1 only.
//  FSM (pos_cnt, neg_cnt, hold_cnt are $clog2(max+1) bits and saturate):
//   CLEAR:   pos -> pos_cnt=1; go STOP if ON_FRAMES==1, else CONFIRM. neg -> stay.
//   CONFIRM: pos -> pos_cnt+1; reaching ON_FRAMES -> STOP, hold_cnt=0.
//            neg -> CLEAR, pos_cnt=0.
//   STOP:    any ev -> hold_cnt+1 (saturating).
//            neg with hold_cnt>=HOLD_FRAMES (value before increment) -> neg_cnt=1;
//            go CLEAR if OFF_FRAMES==1, else RELEASE.
//            neg with hold_cnt<HOLD_FRAMES -> stay STOP.
//   RELEASE: neg -> neg_cnt+1; reaching OFF_FRAMES -> CLEAR, all counters 0.
//            pos -> STOP, neg_cnt=0, hold_cnt kept.
//  stop = 1 in STOP and RELEASE, or whenever stale=1 (fail-safe). 0 otherwise.
//  Watchdog: idle_cnt counts cycles since the last ev, saturating.
//   idle_cnt reaching TIMEOUT_CYC -> stale=1, state forced STOP, hold_cnt=0.
//   The next ev clears stale and idle_cnt, then is processed from STOP.
//  verdict_count increments on every ev, holds at 16'hFFFF.
//  Priority in one cycle: flush > ev > timeout.
//   flush: state=CLEAR, counters=0, stale=0, idle_cnt=0, verdict_count=0, stop_pulse=0.
//  detection_valid held high for many cycles counts as exactly one verdict.
//  A release requires a new edge.
//  stop_pulse also fires when stale forces stop from 0 to 1.
//  It does not fire for STOP<->RELEASE moves, where stop is already 1.
// TESTING
//  1 Three 1-cycle dv pulses with cd=1, 100 cycles apart.
//    -> CLEAR, CONFIRM, CONFIRM, then STOP. stop=1 and stop_pulse=1 in the cycle after the third edge.
//  2 Two pos verdicts, then one neg.
//    -> state CLEAR, stop never 1. Then three pos -> stop=1.
//  3 In STOP, feed 10 neg verdicts.
//    -> stays STOP until hold_cnt reaches 10, then RELEASE.
//    -> 5 more neg -> CLEAR, stop=0 one cycle after the 5th neg edge.
//  4 dv held high 500 cycles with cd=1, from CLEAR -> only one verdict.
//    verdict_count=1, state CONFIRM.
//  5 TIMEOUT_CYC=50, no dv for 50 cycles -> stale=1, stop=1, stop_pulse once, state STOP.
//    Next neg ev -> stale=0.
//  6 rst_n low mid-RELEASE -> all outputs 0 immediately (async).
//    flush and pos ev in same cycle -> CLEAR, verdict_count=0.

Source files
------------

// File: rtl/zebra_stop_filter.sv
// zebra_stop_filter
// Temporal hysteresis between the per-frame zebra verdict and the stop request.
// A verdict is the rising edge of detection_valid, so a level held for many
// cycles counts once. Stop asserts after ON_FRAMES consecutive positives. It is
// held for at least HOLD_FRAMES verdicts. It releases after OFF_FRAMES
// consecutive negatives. A missing verdict stream (stale) forces stop high.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_CLEAR   | no crossing, stop low
// S_CONFIRM | positives accumulating toward ON_FRAMES, stop still low
// S_STOP    | stop high, hold_cnt counts verdicts toward HOLD_FRAMES
// S_RELEASE | stop high, negatives accumulating toward OFF_FRAMES
module zebra_stop_filter #(
    parameter int ON_FRAMES   = 3,
    parameter int OFF_FRAMES  = 5,
    parameter int HOLD_FRAMES = 10,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        detection_valid,
    input  logic        crossing_detected,
    input  logic        flush,
    output logic        stop,
    output logic        stop_pulse,
    output logic        stale,
    output logic [1:0]  state,
    output logic [15:0] verdict_count
);

    // Counter widths are guarded so a parameter of 0 still yields a 1-bit counter.
    localparam int ON_W   = (ON_FRAMES   < 1) ? 1 : $clog2(ON_FRAMES + 1);
    localparam int OFF_W  = (OFF_FRAMES  < 1) ? 1 : $clog2(OFF_FRAMES + 1);
    localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam int IDLE_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

    localparam logic [ON_W-1:0]   ON_MAX   = ON_W'(ON_FRAMES);
    localparam logic [OFF_W-1:0]  OFF_MAX  = OFF_W'(OFF_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

    localparam bit ON_SINGLE  = (ON_FRAMES == 1);
    localparam bit OFF_SINGLE = (OFF_FRAMES == 1);

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_CONFIRM = 2'd1,
        S_STOP    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic              dv_q;
    logic [ON_W-1:0]   pos_cnt;
    logic [ON_W-1:0]   pos_nxt;
    logic [OFF_W-1:0]  neg_cnt;
    logic [OFF_W-1:0]  neg_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_nxt;
    logic [15:0]       vcnt_nxt;
    logic              stale_nxt;
    logic              stop_nxt;

    logic              ev;
    logic              pos;
    logic              neg;
    logic [ON_W-1:0]   pos_inc;
    logic [OFF_W-1:0]  neg_inc;
    logic [HOLD_W-1:0] hold_inc;

    assign ev  = detection_valid & ~dv_q;
    assign pos = ev & crossing_detected;
    assign neg = ev & ~crossing_detected;

    assign pos_inc  = (pos_cnt  == ON_MAX)   ? pos_cnt  : pos_cnt  + ON_W'(1);
    assign neg_inc  = (neg_cnt  == OFF_MAX)  ? neg_cnt  : neg_cnt  + OFF_W'(1);
    assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);

    assign state = state_q;

    // Next-state and counter update: flush beats a verdict, a verdict beats the watchdog.
    always_comb begin
        state_nxt = state_q;
        pos_nxt   = pos_cnt;
        neg_nxt   = neg_cnt;
        hold_nxt  = hold_cnt;
        idle_nxt  = idle_cnt;
        stale_nxt = stale;
        vcnt_nxt  = verdict_count;

        if (flush) begin
            state_nxt = S_CLEAR;
            pos_nxt   = '0;
            neg_nxt   = '0;
            hold_nxt  = '0;
            idle_nxt  = '0;
            stale_nxt = 1'b0;
            vcnt_nxt  = '0;
        end else if (ev) begin
            stale_nxt = 1'b0;
            idle_nxt  = '0;
            if (verdict_count != 16'hFFFF) begin
                vcnt_nxt = verdict_count + 16'd1;
            end
            case (state_q)
                S_CLEAR: begin
                    if (pos) begin
                        pos_nxt  = ON_W'(1);
                        hold_nxt = '0;
                        state_nxt = ON_SINGLE ? S_STOP : S_CONFIRM;
                    end
                end
                S_CONFIRM: begin
                    if (pos) begin
                        pos_nxt = pos_inc;
                        if (pos_inc >= ON_MAX) begin
                            state_nxt = S_STOP;
                            hold_nxt  = '0;
                        end
                    end else begin
                        state_nxt = S_CLEAR;
                        pos_nxt   = '0;
                    end
                end
                S_STOP: begin
                    hold_nxt = hold_inc;
                    // The hold check uses the count before this verdict is added.
                    if (neg && (hold_cnt >= HOLD_MAX)) begin
                        if (OFF_SINGLE) begin
                            state_nxt = S_CLEAR;
                            pos_nxt   = '0;
                            neg_nxt   = '0;
                            hold_nxt  = '0;
                        end else begin
                            state_nxt = S_RELEASE;
                            neg_nxt   = OFF_W'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    if (neg) begin
                        if (neg_inc >= OFF_MAX) begin
                            state_nxt = S_CLEAR;
                            pos_nxt   = '0;
                            neg_nxt   = '0;
                            hold_nxt  = '0;
                        end else begin
                            neg_nxt = neg_inc;
                        end
                    end else begin
                        // A positive aborts the release; hold_cnt is kept so an
                        // already satisfied hold does not restart.
                        state_nxt = S_STOP;
                        neg_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_CLEAR;
                end
            endcase
        end else if (idle_cnt != IDLE_MAX) begin
            idle_nxt = idle_cnt + IDLE_W'(1);
            // The watchdog fires once, on the cycle the idle count reaches its limit.
            if (idle_nxt == IDLE_MAX) begin
                stale_nxt = 1'b1;
                state_nxt = S_STOP;
                hold_nxt  = '0;
                neg_nxt   = '0;
            end
        end

        stop_nxt = (state_nxt == S_STOP) || (state_nxt == S_RELEASE) || stale_nxt;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Counters, edge detector and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q          <= 1'b0;
            pos_cnt       <= '0;
            neg_cnt       <= '0;
            hold_cnt      <= '0;
            idle_cnt      <= '0;
            stale         <= 1'b0;
            stop          <= 1'b0;
            stop_pulse    <= 1'b0;
            verdict_count <= '0;
        end else begin
            dv_q          <= detection_valid;
            pos_cnt       <= pos_nxt;
            neg_cnt       <= neg_nxt;
            hold_cnt      <= hold_nxt;
            idle_cnt      <= idle_nxt;
            stale         <= stale_nxt;
            stop          <= stop_nxt;
            stop_pulse    <= stop_nxt & ~stop;
            verdict_count <= vcnt_nxt;
        end
    end

endmodule
